lda_avalon_master: RTL
======================

# lda_avalon_master

Avalon-MM master that drives the line-drawing peripheral's slave register port on behalf of a hardware client. Line commands are accepted through a valid/ready handshake and buffered in a small FIFO. Each command is issued as a sequence of register writes followed by status polling until the peripheral reports idle. The block sits between a command source (e.g. a shape generator) and the LDA peripheral's `avs_s1` port, replacing the Nios II as the bus initiator.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 65535: status-poll cycle limit; used only with `LDA_MASTER_TIMEOUT_EN`.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command; equals !full.
- `cmd_x0`, `cmd_x1`  in  9 each  line endpoint X.
- `cmd_y0`, `cmd_y1`  in  8 each  line endpoint Y.
- `cmd_colour`  in  3  line colour.
- `avm_m1_address`  out  3  slave register address.
- `avm_m1_read`, `avm_m1_write`  out  1 each  transfer strobes; never both high.
- `avm_m1_writedata`  out  32  write data.
- `avm_m1_readdata`  in  32  read data; valid when read=1 and waitrequest=0.
- `avm_m1_waitrequest`  in  1  slave stall.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.
- `lines_done`  out  16  count of completed lines; wraps at 65535 -> 0.
- `error`  out  1  sticky poll timeout (macro only; otherwise tied 0).

## Operation
- Slave register map:
  - 0 MODE: 1 = poll mode.
  - 1 STATUS: bit0 = 1 while drawing.
  - 2 GO: any write starts drawing.
  - 3 START: x0 in [8:0], y0 in [16:9].
  - 4 END: x1 in [8:0], y1 in [16:9].
  - 5 COLOUR: colour in [2:0].
- Unused writedata bits are driven 0.
- FIFO push: `cmd_valid && cmd_ready`. Pop: only when a line completes or times out.
- FSM states: IDLE, WR_MODE, WR_START, WR_END, WR_COLOUR, WR_GO, RD_STATUS.
- IDLE with FIFO non-empty:
  - goes to WR_MODE if `mode_written`=0;
  - otherwise goes to WR_START.
- `mode_written` is set when the MODE write is accepted and cleared only by reset.
- Each WR_* state holds `write`=1 and stable address/data until a cycle with waitrequest=0, then advances: MODE -> START -> END -> COLOUR -> GO -> RD_STATUS.
- RD_STATUS holds `read`=1. On each cycle with waitrequest=0, it samples readdata[0]:
  - 0: pop the FIFO, increment `lines_done`, go to IDLE.
  - 1: stay in RD_STATUS; the next read is issued back-to-back.
- The head FIFO entry supplies all write data and is stable for the whole sequence.

## Timing
- Reset values:
  - cmd_ready=0 while reset is asserted, then 1 from the first cycle after release;
  - strobes 0, address 0, writedata 0, busy 0, lines_done 0, error 0;
  - FIFO empty, FSM in IDLE, mode_written 0.
- Reset mid-transfer abandons the in-flight Avalon transfer immediately and discards all queued commands.
- Command pushed at cycle N into an empty FIFO with FSM idle: first write strobe at N+2 (N+1 FIFO write, N+2 FSM leaves IDLE with registered outputs).
- Zero-waitrequest line, mode already written: 4 write cycles plus at least 1 read cycle, then 1 IDLE cycle. Minimum 6 cycles per line.
- Full FIFO: cmd_ready=0. A pop frees a slot, and cmd_ready rises the cycle after the pop.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- waitrequest held high indefinitely: the FSM stalls in its state with no timeout, except in RD_STATUS when the macro is enabled.

## Configuration
- `LDA_MASTER_TIMEOUT_EN` defined:
  - a cycle counter runs while in RD_STATUS;
  - after `TIMEOUT_CYCLES` cycles without reading bit0=0, `error` sets (sticky until reset), the head command is popped, `lines_done` is not incremented, and the FSM returns to IDLE.
- Macro undefined: no counter; `error` is constant 0; polling is unbounded.

## Test plan
- Reset, then one command (x0=10, y0=20, x1=100, y1=50, colour=3), slave with waitrequest=0 and STATUS=0:
  - writes, in order: addr0=1, addr3=0x0280A, addr4=0x06464, addr5=3, addr2;
  - then one read of addr1;
  - lines_done=1, busy=0.
- Second command after the first: no MODE write; writes start at addr3.
- waitrequest high for 3 cycles during the END write: address and writedata stay stable for 4 cycles, and sequence order is preserved.
- STATUS returns 1 for 5 reads, then 0: exactly 6 reads issued, then the FIFO pops.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and a slow slave: cmd_ready=0 after 4 accepted, and all lines complete in order.
- With `LDA_MASTER_TIMEOUT_EN` and TIMEOUT_CYCLES=8, STATUS stuck at 1: error=1 after 8 poll cycles, lines_done unchanged, and the next command proceeds.

Source files
------------

// File: rtl/lda_avalon_master.sv
// lda_avalon_master: Avalon-MM master that feeds queued line commands to the
// LDA peripheral's slave port (MODE/START/END/COLOUR/GO writes, then STATUS
// polling until the peripheral reports idle).
// Optional feature macro: LDA_MASTER_TIMEOUT_EN bounds status polling to
// TIMEOUT_CYCLES cycles and raises a sticky error on expiry.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for a queued command
// WR_MODE      | writing MODE=1 (first line after reset only)
// WR_START     | writing x0/y0 of the head command
// WR_END       | writing x1/y1 of the head command
// WR_COLOUR    | writing the colour of the head command
// WR_GO        | writing GO to launch the draw
// RD_STATUS    | polling STATUS until bit0 reads 0 (or the poll timer expires)
module lda_avalon_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [8:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  input  logic [2:0]  cmd_colour,
  output logic [2:0]  avm_m1_address,
  output logic        avm_m1_read,
  output logic        avm_m1_write,
  output logic [31:0] avm_m1_writedata,
  input  logic [31:0] avm_m1_readdata,
  input  logic        avm_m1_waitrequest,
  output logic        busy,
  output logic [15:0] lines_done,
  output logic        error
);

  localparam int AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int CMD_W = 37;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_MODE   = 3'd1;
  localparam logic [2:0] S_WR_START  = 3'd2;
  localparam logic [2:0] S_WR_END    = 3'd3;
  localparam logic [2:0] S_WR_COLOUR = 3'd4;
  localparam logic [2:0] S_WR_GO     = 3'd5;
  localparam logic [2:0] S_RD_STATUS = 3'd6;

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_GO     = 3'd2;
  localparam logic [2:0] A_START  = 3'd3;
  localparam logic [2:0] A_END    = 3'd4;
  localparam logic [2:0] A_COLOUR = 3'd5;

  // command FIFO
  logic [CMD_W-1:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q;
  logic             push, pop;
  logic [CMD_W-1:0] cmd_word, head;
  logic [8:0]       head_x0, head_x1;
  logic [7:0]       head_y0, head_y1;
  logic [2:0]       head_colour;

  // sequencer
  logic [2:0]  state_q, state_d;
  logic        mode_written_q;
  logic        mode_set;
  logic        done_inc;
  logic        status_done;
  logic        tmo_expired;
  logic [15:0] lines_q;

  // registered bus outputs
  logic [2:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [31:0] wd_q, wd_d;

  logic unused_rd;
  assign unused_rd = ^avm_m1_readdata[31:1];

  assign cmd_word    = {cmd_colour, cmd_y1, cmd_x1, cmd_y0, cmd_x0};
  assign head        = fifo_q[rd_ptr_q];
  assign head_x0     = head[8:0];
  assign head_y0     = head[16:9];
  assign head_x1     = head[25:17];
  assign head_y1     = head[33:26];
  assign head_colour = head[36:34];

  assign push = cmd_valid && rdy_q;

  // Occupancy next-state; simultaneous push and pop leave it unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd_word;
    end
  end

  // FIFO pointers, occupancy and registered ready (low during reset)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CW'(FIFO_DEPTH));
    end
  end

  assign status_done = (state_q == S_RD_STATUS) && !avm_m1_waitrequest &&
                       !avm_m1_readdata[0];

  // Sequencer next-state: each bus state advances on a cycle without waitrequest
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    done_inc = 1'b0;
    mode_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          state_d = mode_written_q ? S_WR_START : S_WR_MODE;
        end
      end
      S_WR_MODE: begin
        if (!avm_m1_waitrequest) begin
          state_d  = S_WR_START;
          mode_set = 1'b1;
        end
      end
      S_WR_START: begin
        if (!avm_m1_waitrequest) state_d = S_WR_END;
      end
      S_WR_END: begin
        if (!avm_m1_waitrequest) state_d = S_WR_COLOUR;
      end
      S_WR_COLOUR: begin
        if (!avm_m1_waitrequest) state_d = S_WR_GO;
      end
      S_WR_GO: begin
        if (!avm_m1_waitrequest) state_d = S_RD_STATUS;
      end
      S_RD_STATUS: begin
        if (status_done) begin
          pop      = 1'b1;
          done_inc = 1'b1;
          state_d  = S_IDLE;
        end else if (tmo_expired) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, MODE-written flag and completed-line counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      mode_written_q <= 1'b0;
      lines_q        <= 16'd0;
    end else begin
      state_q <= state_d;
      if (mode_set) begin
        mode_written_q <= 1'b1;
      end
      if (done_inc) begin
        lines_q <= lines_q + 16'd1;
      end
    end
  end

  // Bus outputs decoded from the upcoming state so they are registered and
  // stay stable for as long as the state is held by waitrequest
  always_comb begin
    addr_d = A_MODE;
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    wd_d   = 32'd0;
    case (state_d)
      S_WR_MODE: begin
        addr_d = A_MODE;
        wr_d   = 1'b1;
        wd_d   = 32'd1;
      end
      S_WR_START: begin
        addr_d = A_START;
        wr_d   = 1'b1;
        wd_d   = {15'd0, head_y0, head_x0};
      end
      S_WR_END: begin
        addr_d = A_END;
        wr_d   = 1'b1;
        wd_d   = {15'd0, head_y1, head_x1};
      end
      S_WR_COLOUR: begin
        addr_d = A_COLOUR;
        wr_d   = 1'b1;
        wd_d   = {29'd0, head_colour};
      end
      S_WR_GO: begin
        addr_d = A_GO;
        wr_d   = 1'b1;
      end
      S_RD_STATUS: begin
        addr_d = A_STATUS;
        rd_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= 3'd0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      wd_q   <= 32'd0;
    end else begin
      addr_q <= addr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
    end
  end

`ifdef LDA_MASTER_TIMEOUT_EN
  localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tmo_q;
  logic        error_q;

  assign tmo_expired = (state_q == S_RD_STATUS) && (tmo_q == 32'd0);

  // Poll timer: reloads outside RD_STATUS, counts down to terminal count while polling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= TMO_LOAD;
    end else if (state_q != S_RD_STATUS) begin
      tmo_q <= TMO_LOAD;
    end else if (tmo_q != 32'd0) begin
      tmo_q <= tmo_q - 32'd1;
    end
  end

  // Sticky error when the timer expires without a completing status read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (tmo_expired && !status_done) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;

  assign tmo_expired = 1'b0;
  assign error       = 1'b0;
`endif

  assign cmd_ready        = rdy_q;
  assign avm_m1_address   = addr_q;
  assign avm_m1_read      = rd_q;
  assign avm_m1_write     = wr_q;
  assign avm_m1_writedata = wd_q;
  assign busy             = (state_q != S_IDLE) || (cnt_q != '0);
  assign lines_done       = lines_q;

endmodule
